// File: rtl/clock_edge_receiver.sv
// Receives a divided or asynchronous slow clock and turns it into rise/fall enables, an edge count and a lock monitor.
// Optional define GLITCH_FILTER_EN adds a two-sample agreement filter after the synchroniser.
module clock_edge_receiver #(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int COUNT_WIDTH    = 16
) (
  input  logic                   input_clock,
  input  logic                   reset,
  input  logic                   slow_clock,
  input  logic                   tick_clear,
  output logic                   rise_pulse,
  output logic                   fall_pulse,
  output logic [COUNT_WIDTH-1:0] tick_count,
  output logic                   clock_alive,
  output logic                   timeout_pulse
);

  localparam int WD_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, LOCKED = 2'd1, LOST = 2'd2} state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   level_s;
  logic                   prev_q;
  logic                   rise_s;
  logic                   fall_s;
  logic                   edge_s;
  logic                   rise_pulse_q;
  logic                   fall_pulse_q;
  logic [COUNT_WIDTH-1:0] tick_q;
  logic [COUNT_WIDTH-1:0] tick_d;
  logic [WD_W-1:0]        wd_q;
  logic [WD_W-1:0]        wd_d;
  state_t                 state_q;
  logic                   alive_q;
  logic                   timeout_q;

  // Synchroniser chain; sync_q[0] is the first stage.
  always_ff @(posedge input_clock or negedge reset) begin
    if (!reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], slow_clock};
    end
  end

`ifdef GLITCH_FILTER_EN
  logic filt_q;

  // Accept a new level only when the last two synchroniser stages agree on it.
  always_ff @(posedge input_clock or negedge reset) begin
    if (!reset) begin
      filt_q <= 1'b0;
    end else if (sync_q[SYNC_STAGES-1] == sync_q[SYNC_STAGES-2]) begin
      filt_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level_s = filt_q;
`else
  assign level_s = sync_q[SYNC_STAGES-1];
`endif

  assign rise_s = level_s & ~prev_q;
  assign fall_s = ~level_s & prev_q;
  assign edge_s = rise_s | fall_s;

  // Next-state for the tick counter and the saturating watchdog.
  always_comb begin
    tick_d = tick_q;
    wd_d   = wd_q;
    if (tick_clear) begin
      tick_d = COUNT_WIDTH'(rise_pulse_q);
    end else begin
      tick_d = tick_q + COUNT_WIDTH'(rise_pulse_q);
    end
    if (edge_s) begin
      wd_d = {WD_W{1'b0}};
    end else if (wd_q == WD_MAX) begin
      wd_d = wd_q;
    end else begin
      wd_d = wd_q + {{(WD_W-1){1'b0}}, 1'b1};
    end
  end

  // Edge detector, registered pulses and counters.
  always_ff @(posedge input_clock or negedge reset) begin
    if (!reset) begin
      prev_q       <= 1'b0;
      rise_pulse_q <= 1'b0;
      fall_pulse_q <= 1'b0;
      tick_q       <= '0;
      wd_q         <= '0;
    end else begin
      prev_q       <= level_s;
      rise_pulse_q <= rise_s;
      fall_pulse_q <= fall_s;
      tick_q       <= tick_d;
      wd_q         <= wd_d;
    end
  end

  // Lock monitor; an edge in the expiry cycle keeps the lock.
  always_ff @(posedge input_clock or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      alive_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      case (state_q)
        IDLE, LOST: begin
          if (rise_s) begin
            state_q <= LOCKED;
            alive_q <= 1'b1;
          end
        end
        LOCKED: begin
          if (!edge_s && (wd_q == WD_MAX)) begin
            state_q   <= LOST;
            alive_q   <= 1'b0;
            timeout_q <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          alive_q <= 1'b0;
        end
      endcase
    end
  end

  assign rise_pulse    = rise_pulse_q;
  assign fall_pulse    = fall_pulse_q;
  assign tick_count    = tick_q;
  assign clock_alive   = alive_q;
  assign timeout_pulse = timeout_q;

endmodule

// File: tb/tb_clock_edge_receiver.sv
// Directed bench for clock_edge_receiver with SYNC_STAGES=2, TIMEOUT_CYCLES=64, COUNT_WIDTH=4.
module tb_clock_edge_receiver;

  localparam int SS = 2;
  localparam int TO = 64;
  localparam int CW = 4;
`ifdef GLITCH_FILTER_EN
  localparam int FL = 1;
`else
  localparam int FL = 0;
`endif
  // Edges after the first high sample until rise_pulse is visible (minus one).
  localparam int D = SS + FL;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          slow = 1'b0;
  logic          clr = 1'b0;
  logic          rise_pulse;
  logic          fall_pulse;
  logic [CW-1:0] tick_count;
  logic          clock_alive;
  logic          timeout_pulse;

  int total = 0;
  int bad = 0;

  clock_edge_receiver #(
    .SYNC_STAGES(SS),
    .TIMEOUT_CYCLES(TO),
    .COUNT_WIDTH(CW)
  ) dut (
    .input_clock  (clk),
    .reset        (rst_n),
    .slow_clock   (slow),
    .tick_clear   (clr),
    .rise_pulse   (rise_pulse),
    .fall_pulse   (fall_pulse),
    .tick_count   (tick_count),
    .clock_alive  (clock_alive),
    .timeout_pulse(timeout_pulse)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic period();
    slow = 1'b0;
    cyc(2);
    slow = 1'b1;
    cyc(2);
  endtask

  initial begin
    int er, ef, ec, ea, et, tc, nr, nf;

    // Reset state
    cyc(3);
    chk("rst_rise", 32'(rise_pulse), 32'd0);
    chk("rst_fall", 32'(fall_pulse), 32'd0);
    chk("rst_count", 32'(tick_count), 32'd0);
    chk("rst_alive", 32'(clock_alive), 32'd0);
    chk("rst_timeout", 32'(timeout_pulse), 32'd0);
    rst_n = 1'b1;

    // Period-4 toggling with 17 rises (count wraps), then held low until timeout
    for (int t = 0; t <= D + 138; t++) begin
      slow = (t < 68) ? (((t >> 1) & 1) == 0) : 1'b0;
      cyc(1);
      er = (t >= D && t <= D + 64 && (t - D) % 4 == 0) ? 1 : 0;
      ef = (t >= D + 2 && t <= D + 66 && (t - D - 2) % 4 == 0) ? 1 : 0;
      tc = (t < D + 65) ? t : D + 65;
      ec = (t >= D + 1) ? (((tc - D - 1) / 4 + 1) % 16) : 0;
      ea = (t >= D && t < D + 130) ? 1 : 0;
      et = (t == D + 130) ? 1 : 0;
      chk($sformatf("rise@t%0d", t), 32'(rise_pulse), 32'(er));
      chk($sformatf("fall@t%0d", t), 32'(fall_pulse), 32'(ef));
      chk($sformatf("count@t%0d", t), 32'(tick_count), 32'(ec));
      chk($sformatf("alive@t%0d", t), 32'(clock_alive), 32'(ea));
      chk($sformatf("timeout@t%0d", t), 32'(timeout_pulse), 32'(et));
    end

    // Resume after loss: relock with the first rise_pulse
    slow = 1'b1;
    cyc(D);
    chk("relock_pre_rise", 32'(rise_pulse), 32'd0);
    chk("relock_pre_alive", 32'(clock_alive), 32'd0);
    cyc(1);
    chk("relock_rise", 32'(rise_pulse), 32'd1);
    chk("relock_alive", 32'(clock_alive), 32'd1);
    chk("relock_timeout", 32'(timeout_pulse), 32'd0);
    cyc(1);
    chk("relock_count", 32'(tick_count), 32'd2);

    // tick_clear alone, then build count to 5, clear coincident with rise, clear alone
    clr = 1'b1;
    cyc(1);
    clr = 1'b0;
    chk("clear_alone_a", 32'(tick_count), 32'd0);
    repeat (5) period();
    cyc(D);
    chk("count_five", 32'(tick_count), 32'd5);
    slow = 1'b0;
    cyc(2);
    slow = 1'b1;
    cyc(D + 1);
    chk("coinc_rise", 32'(rise_pulse), 32'd1);
    chk("coinc_pre_count", 32'(tick_count), 32'd5);
    clr = 1'b1;
    cyc(1);
    clr = 1'b0;
    chk("clear_with_rise", 32'(tick_count), 32'd1);
    clr = 1'b1;
    cyc(1);
    clr = 1'b0;
    chk("clear_alone_b", 32'(tick_count), 32'd0);

    // Asynchronous reset mid-stream with count 9 and lock held
    repeat (9) period();
    cyc(D);
    chk("pre_reset_count", 32'(tick_count), 32'd9);
    chk("pre_reset_alive", 32'(clock_alive), 32'd1);
    slow = 1'b0;
    cyc(1);
    rst_n = 1'b0;
    #1;
    chk("async_rise", 32'(rise_pulse), 32'd0);
    chk("async_fall", 32'(fall_pulse), 32'd0);
    chk("async_count", 32'(tick_count), 32'd0);
    chk("async_alive", 32'(clock_alive), 32'd0);
    chk("async_timeout", 32'(timeout_pulse), 32'd0);
    cyc(2);
    rst_n = 1'b1;
    cyc(3);
    chk("post_reset_alive", 32'(clock_alive), 32'd0);
    chk("post_reset_count", 32'(tick_count), 32'd0);
    chk("post_reset_fall", 32'(fall_pulse), 32'd0);
    slow = 1'b1;
    cyc(D);
    chk("post_reset_pre_rise", 32'(rise_pulse), 32'd0);
    cyc(1);
    chk("post_reset_rise", 32'(rise_pulse), 32'd1);
    chk("post_reset_lock", 32'(clock_alive), 32'd1);
    cyc(1);
    chk("post_reset_first_count", 32'(tick_count), 32'd1);

    // Single-cycle high glitch
    slow = 1'b0;
    cyc(D + 4);
    chk("glitch_pre_count", 32'(tick_count), 32'd1);
    slow = 1'b1;
    cyc(1);
    slow = 1'b0;
    nr = 0;
    nf = 0;
    for (int i = 0; i < 8; i++) begin
      cyc(1);
      nr += int'(rise_pulse);
      nf += int'(fall_pulse);
    end
`ifdef GLITCH_FILTER_EN
    chk("glitch_rises", 32'(nr), 32'd0);
    chk("glitch_falls", 32'(nf), 32'd0);
    chk("glitch_count", 32'(tick_count), 32'd1);
`else
    chk("glitch_rises", 32'(nr), 32'd1);
    chk("glitch_falls", 32'(nf), 32'd1);
    chk("glitch_count", 32'(tick_count), 32'd2);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
